// File: rtl/div_sequencer_if.sv
// ============================================================================
// div_sequencer_if : request/result and comparator bundle for div_sequencer
// Optional div_err member present when DIV_BY_ZERO_EN is defined.
// Revision: 1.0
// ============================================================================
`default_nettype none

interface div_sequencer_if #(
  parameter int WIDTH = 16
);
  logic             start;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic [WIDTH-1:0] cmp_divisible;
  logic [WIDTH-1:0] cmp_divider;
  logic             cmp_ready;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] quotient;
  logic [WIDTH-1:0] remainder;
`ifdef DIV_BY_ZERO_EN
  logic             div_err;

  modport master (
    output start, A, B, cmp_divisible, cmp_divider, cmp_ready,
    input  op_a, op_b, busy, done, quotient, remainder, div_err
  );

  modport slave (
    input  start, A, B, cmp_divisible, cmp_divider, cmp_ready,
    output op_a, op_b, busy, done, quotient, remainder, div_err
  );
`else
  modport master (
    output start, A, B, cmp_divisible, cmp_divider, cmp_ready,
    input  op_a, op_b, busy, done, quotient, remainder
  );

  modport slave (
    input  start, A, B, cmp_divisible, cmp_divider, cmp_ready,
    output op_a, op_b, busy, done, quotient, remainder
  );
`endif
endinterface

`default_nettype wire

// File: rtl/div_sequencer.sv
// ============================================================================
// div_sequencer : multi-cycle unsigned restoring divider controller driving an
// external operand-ordering comparator. Macro DIV_BY_ZERO_EN adds div_err.
// Revision: 1.0
// ============================================================================
`default_nettype none

module div_sequencer #(
  parameter int WIDTH = 16
) (
  input  wire logic      clk,
  input  wire logic      res,
  div_sequencer_if.slave bus
);

  localparam int             CW         = $clog2(WIDTH + 1);
  localparam logic [CW-1:0]  C_CNT_INIT = CW'(WIDTH);
  localparam logic [CW-1:0]  C_CNT_ONE  = CW'(1);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_LOAD = 3'd1,
    S_CMP  = 3'd2,
    S_DIV  = 3'd3,
    S_DONE = 3'd4
  } state_t;

  state_t           r_state;
  logic [WIDTH-1:0] r_op_a;
  logic [WIDTH-1:0] r_op_b;
  logic [WIDTH-1:0] r_quotient;
  logic [WIDTH-1:0] r_remainder;
  // A kept partial remainder is always below the divisor, so WIDTH bits hold it.
  logic [WIDTH-1:0] r_rem;
  logic [WIDTH-1:0] r_quo;
  logic [WIDTH-1:0] r_den;
  logic [CW-1:0]    r_cnt;
  logic             r_busy;
  logic             r_done;
`ifdef DIV_BY_ZERO_EN
  logic             r_div_err;
`endif

  logic [WIDTH:0]   w_shift;
  logic [WIDTH:0]   w_trial;
  logic             w_fits;
  logic [WIDTH-1:0] w_rem_next;
  logic [WIDTH-1:0] w_quo_next;
  logic             w_zero_div;
  logic             w_last;

  assign w_shift    = {r_rem, r_quo[WIDTH-1]};
  assign w_trial    = w_shift - {1'b0, r_den};
  assign w_fits     = ~w_trial[WIDTH];
  assign w_rem_next = w_fits ? w_trial[WIDTH-1:0] : w_shift[WIDTH-1:0];
  assign w_quo_next = {r_quo[WIDTH-2:0], w_fits};
  assign w_last     = (r_cnt == C_CNT_ONE);

  assign w_zero_div = (bus.cmp_ready && (bus.cmp_divider == '0)) ||
                      (!bus.cmp_ready && (r_op_a == '0));

  always_ff @(posedge clk or posedge res) begin
    if (res) begin
      r_state     <= S_IDLE;
      r_op_a      <= '0;
      r_op_b      <= '0;
      r_quotient  <= '0;
      r_remainder <= '0;
      r_rem       <= '0;
      r_quo       <= '0;
      r_den       <= '0;
      r_cnt       <= '0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
`ifdef DIV_BY_ZERO_EN
      r_div_err   <= 1'b0;
`endif
    end else begin
      case (r_state)
        S_IDLE: begin
          if (bus.start) begin
            r_op_a      <= bus.A;
            r_op_b      <= bus.B;
            r_quotient  <= '0;
            r_remainder <= '0;
            r_busy      <= 1'b1;
`ifdef DIV_BY_ZERO_EN
            r_div_err   <= 1'b0;
`endif
            r_state     <= S_LOAD;
          end
        end

        S_LOAD: begin
          r_state <= S_CMP;
        end

        S_CMP: begin
          if (w_zero_div) begin
`ifdef DIV_BY_ZERO_EN
            r_quotient  <= '0;
            r_remainder <= '0;
            r_div_err   <= 1'b1;
`else
            r_quotient  <= '1;
            r_remainder <= bus.cmp_ready ? bus.cmp_divisible : '0;
`endif
            r_done      <= 1'b1;
            r_state     <= S_DONE;
          end else if (!bus.cmp_ready) begin
            r_quotient  <= WIDTH'(1);
            r_remainder <= '0;
            r_done      <= 1'b1;
            r_state     <= S_DONE;
          end else begin
            r_rem   <= '0;
            r_quo   <= bus.cmp_divisible;
            r_den   <= bus.cmp_divider;
            r_cnt   <= C_CNT_INIT;
            r_state <= S_DIV;
          end
        end

        S_DIV: begin
          r_rem <= w_rem_next;
          r_quo <= w_quo_next;
          r_cnt <= r_cnt - C_CNT_ONE;
          if (w_last) begin
            r_quotient  <= w_quo_next;
            r_remainder <= w_rem_next;
            r_done      <= 1'b1;
            r_state     <= S_DONE;
          end
        end

        S_DONE: begin
          r_done  <= 1'b0;
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end

        default: begin
          r_done  <= 1'b0;
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.op_a      = r_op_a;
  assign bus.op_b      = r_op_b;
  assign bus.busy      = r_busy;
  assign bus.done      = r_done;
  assign bus.quotient  = r_quotient;
  assign bus.remainder = r_remainder;
`ifdef DIV_BY_ZERO_EN
  assign bus.div_err   = r_div_err;
`endif

endmodule

`default_nettype wire
